// File: rtl/spi_slave_pkg.sv
// SPI mode constants, FSM encoding and default transmit byte for the spi_slave block.
// Latency: none (constants only); backpressure: n/a.
package spi_slave_pkg;

  localparam bit CPOL = 1'b1;
  localparam bit CPHA = 1'b1;
  // Modes 0 and 3 capture MOSI on the rising SCLK edge and drive MISO on the falling one.
  localparam bit SAMPLE_ON_RISE = CPOL ~^ CPHA;

  localparam logic [7:0] DEFAULT_TX_VAL = 8'hFF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus tx holding-register handshake and rx byte strobe; tx_underrun exists only
// with SPI_SLAVE_UNDERRUN_EN. Backpressure: tx_valid held until tx_ready.
interface spi_slave_if;

  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_end;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       tx_underrun;
`endif

  modport slave (
    input  cs_n, sclk, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_end
`ifdef SPI_SLAVE_UNDERRUN_EN
    , output tx_underrun
`endif
  );

  modport master (
    output cs_n, sclk, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_end
`ifdef SPI_SLAVE_UNDERRUN_EN
    , input tx_underrun
`endif
  );

endinterface

// File: rtl/spi_slave_pin_sync.sv
// N-bit 2-flop synchroniser with optional third register for rise/fall detection.
// Latency: 2 clk to q, edge pulses combinational from stage 2 vs 3; no backpressure.
module spi_pin_sync #(
  parameter int             N       = 1,
  parameter bit             EDGE    = 1'b1,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] s1;
  logic [N-1:0] s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

  generate
    if (EDGE) begin : g_edge
      logic [N-1:0] s3;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) s3 <= RST_VAL;
        else     s3 <= s2;
      end
      assign rise = s2 & ~s3;
      assign fall = ~s2 & s3;
    end else begin : g_no_edge
      assign rise = '0;
      assign fall = '0;
    end
  endgenerate

endmodule

// File: rtl/spi_slave.sv
// SPI mode-3 responder oversampled by clk; pin edges act 3 clk later; tx byte via one-entry
// holding register (tx_ready low while full). Optional SPI_SLAVE_UNDERRUN_EN adds tx_underrun.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter logic [7:0] DEFAULT_TX = DEFAULT_TX_VAL
) (
  input  logic       clk,
  input  logic       rst,
  spi_slave_if.slave bus
);

  state_t     state;
  logic       cs_n_lvl_unused, sclk_lvl_unused, mosi_sync;
  logic       cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic       mosi_rise_unused, mosi_fall_unused;
  logic       shift_edge, sample_edge;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift, rx_shift, rx_data;
  logic       rx_valid, frame_end, miso;
  logic       hold_full;
  logic [7:0] hold_dat, reload_dat;
  logic       reload, tx_write;

  spi_pin_sync #(.N(1), .EDGE(1'b1), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(bus.cs_n), .q(cs_n_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.N(1), .EDGE(1'b1), .RST_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(bus.sclk), .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.N(1), .EDGE(1'b0), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(bus.mosi), .q(mosi_sync), .rise(mosi_rise_unused),
    .fall(mosi_fall_unused)
  );

  assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
  assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;

  // A reload samples the holding register as it was before this edge.
  assign reload_dat = hold_full ? hold_dat : DEFAULT_TX;
  assign tx_write   = bus.tx_valid && !hold_full;
  assign reload     = (state == IDLE) ? cs_fall
                                      : (!cs_rise && sample_edge && (bit_cnt == 3'd7));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_end <= 1'b0;
      miso      <= 1'b1;
    end else begin
      rx_valid  <= 1'b0;
      frame_end <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            tx_shift <= reload_dat;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state     <= IDLE;
            frame_end <= 1'b1;
            bit_cnt   <= '0;
            miso      <= 1'b1;
          end else if (shift_edge) begin
            miso     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end else if (sample_edge) begin
            rx_shift <= {rx_shift[6:0], mosi_sync};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data  <= {rx_shift[6:0], mosi_sync};
              rx_valid <= 1'b1;
              tx_shift <= reload_dat;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_dat  <= '0;
    end else if (tx_write) begin
      hold_full <= 1'b1;
      hold_dat  <= bus.tx_data;
    end else if (reload) begin
      hold_full <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) underrun <= 1'b0;
    else     underrun <= reload && !hold_full;
  end
  assign bus.tx_underrun = underrun;
`endif

  assign bus.miso      = miso;
  assign bus.miso_oe   = (state == SHIFT);
  assign bus.busy      = (state == SHIFT);
  assign bus.tx_ready  = !hold_full;
  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.frame_end = frame_end;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI Mode 3 (CPOL=1, CPHA=1) responder that oversamples the asynchronous SPI pins with the system clock. It is the counterpart of the design's SPI initiator and is used for loopback test and for exposing the filter core to an external host. Each byte received on MOSI is delivered as a one-cycle strobe. Each byte sent on MISO comes from a one-entry transmit holding register filled over a valid/ready handshake.

## Interface
- `DEFAULT_TX`, 8'hFF: byte shifted out when no transmit byte is pending at a byte boundary.
- `clk` input 1: system clock. All logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cs_n` input 1: chip select, active low, asynchronous.
- `sclk` input 1: SPI clock, asynchronous, idles high.
- `mosi` input 1: serial data in, asynchronous.
- `miso` output 1: serial data out.
- `miso_oe` output 1: MISO output enable, high while selected.
- `tx_data` input 8: byte to transmit.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: holding register is empty.
- `rx_data` output 8: last received byte.
- `rx_valid` output 1: one-cycle strobe that `rx_data` was updated.
- `busy` output 1: a frame is in progress.
- `frame_end` output 1: one-cycle strobe on deselect.
- `tx_underrun` output 1: present only with `SPI_SLAVE_UNDERRUN_EN`.

## Operation
- **Synchronisation:** `cs_n`, `sclk` and `mosi` each pass through 2-flop synchronisers. A third register on `sclk` and `cs_n` provides edge detection.
- **FSM states:**
  - IDLE: `busy`=0, `miso_oe`=0.
  - SHIFT: `busy`=1, `miso_oe`=1.
- **IDLE -> SHIFT** on a synchronised `cs_n` falling edge:
  - `bit_cnt` is cleared.
  - The tx shift register loads from the holding register if it is full, which empties it; otherwise it loads `DEFAULT_TX`.
- **SCLK falling edge in SHIFT:** `miso` <= `tx_shift[7]`, and `tx_shift` shifts left by 1.
- **SCLK rising edge in SHIFT:** `rx_shift` <= {`rx_shift[6:0]`, `mosi_sync`}, and `bit_cnt` increments.
- **Byte completion** (rising edge with `bit_cnt`==7):
  - `rx_data` <= {`rx_shift[6:0]`, `mosi_sync`} and `rx_valid` pulses for one cycle.
  - `bit_cnt` wraps to 0.
  - `tx_shift` reloads with the same rule as frame start.
  - The frame continues in SHIFT.
- **SHIFT -> IDLE** on a synchronised `cs_n` rising edge:
  - `frame_end` pulses for one cycle.
  - A partial byte is discarded: no `rx_valid`, and `bit_cnt` is cleared.
  - The holding register keeps its content if it has not been consumed.
- **Holding register:**
  - `tx_ready` = !full.
  - `tx_valid && tx_ready` writes `tx_data` and sets full.
  - If a write and a reload happen in the same cycle, the reload sees the old state. An empty register gives `DEFAULT_TX`, and the new byte is kept for the next boundary.
- SCLK edges are ignored in IDLE. A `cs_n` edge takes priority over an SCLK edge detected in the same cycle.

## Timing
- **Reset values:**
  - `miso`=1, `miso_oe`=0, `tx_ready`=1, `rx_data`=0.
  - `rx_valid`=0, `busy`=0, `frame_end`=0, `tx_underrun`=0.
  - FSM in IDLE, shift registers cleared.
- **Pin-to-action latency:** 3 `clk` cycles from a pin edge to its registered effect (2 sync stages plus edge register). `rx_valid` asserts 3 cycles after the 8th SCLK rising edge.
- **SCLK limits:** each SCLK phase must last at least 4 `clk` cycles. Setup from CS fall to the first SCLK fall must be at least 4 `clk` cycles. This is compatible with the initiator at CLK_DIV ≥ 4.
- `miso` changes 3 cycles after each SCLK fall and is stable through the following rise.
- **Reset mid-frame:** immediate return to the reset values, and the holding register is emptied.

## Configuration
- `SPI_SLAVE_UNDERRUN_EN`:
  - **Defined:** the `tx_underrun` port exists and pulses for one cycle at every reload that uses `DEFAULT_TX` because the holding register is empty.
  - **Undefined:** the port and its logic are absent, and `DEFAULT_TX` is substituted silently.

## Structure
- The shared package holds the SPI mode constants (CPOL/CPHA), the FSM state encoding (IDLE, SHIFT) and the default `DEFAULT_TX` value.
- One sub-module is natural: `spi_pin_sync`, a parameterised N-bit 2-flop synchroniser with an edge-detect register. It is instantiated for `cs_n` and `sclk`, and without edge detect for `mosi`.

## Test plan
- **Basic byte:** preload `tx_data`=8'hA5, drive the initiator (CLK_DIV=5) with 8'h3C. Required: initiator `data_out`=8'hA5, one `rx_valid` with `rx_data`=8'h3C, one `frame_end` after deselect.
- **Multi-byte frame:** load 8'h01 then 8'h02 over the handshake, send 8'hF0 and 8'h0F in one CS frame. Required: MISO bytes 01, 02 and `rx_valid` twice with F0, 0F.
- **Underrun:** no tx byte loaded, send 8'h55. Required: MISO byte = 8'hFF and, with the macro defined, exactly one `tx_underrun` pulse.
- **Abort:** deassert `cs_n` after 5 SCLK cycles. Required: no `rx_valid`, `frame_end` pulses, next full frame receives 8'h81 correctly.
- **Handshake stall:** hold `tx_valid` with 8'hC3 while the register is full. Required: `tx_ready`=0 until the boundary reload, then the write completes and 8'hC3 is sent in the next byte.
- **Reset mid-frame:** assert `rst` after the 3rd bit. Required: all outputs at reset values within the same cycle, `tx_ready`=1.
